// File: rtl/xc_rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : xc_rf_wb_arbiter_if
// Brief   : Requester-side handshake bundle and register-file write port
//           shared between the write-back arbiter and its environment.
// Revision: 1.0 - initial release
// ============================================================================
interface xc_rf_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [5*NREQ-1:0]      req_addr;
    logic [NREQ-1:0]        req_wide;
    logic [2*XLEN*NREQ-1:0] req_wdata;
    logic                   rd_wen;
    logic [4:0]             rd_addr;
    logic [XLEN-1:0]        rd_wdata;
    logic                   busy;

    modport master (
        output req_valid, req_addr, req_wide, req_wdata,
        input  req_ready, rd_wen, rd_addr, rd_wdata, busy
    );

    modport slave (
        input  req_valid, req_addr, req_wide, req_wdata,
        output req_ready, rd_wen, rd_addr, rd_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/xc_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : xc_rf_wb_arbiter
// Brief   : Write-back arbiter for the GPR rd port; splits wide results into
//           even/odd pair writes. Define XC_RF_WB_ROUND_ROBIN_EN for
//           round-robin arbitration (fixed lowest-index priority otherwise).
// Revision: 1.0 - initial release
// ============================================================================
module xc_rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                  i_clock,
    input  logic                  i_resetn,
    xc_rf_wb_arbiter_if.slave     bus
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HIGH = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_rd_wen;
    logic [4:0]             r_rd_addr;
    logic [XLEN-1:0]        r_rd_wdata;
    logic [4:0]             r_hi_addr;
    logic [XLEN-1:0]        r_hi_wdata;

    logic                   w_rd_wen_nxt;
    logic [4:0]             w_rd_addr_nxt;
    logic [XLEN-1:0]        w_rd_wdata_nxt;
    logic [4:0]             w_hi_addr_nxt;
    logic [XLEN-1:0]        w_hi_wdata_nxt;

    logic                   w_found;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic                   w_fire;
    logic [NREQ-1:0]        w_ready;
    logic [4:0]             w_sel_addr;
    logic                   w_sel_wide;
    logic [2*XLEN-1:0]      w_sel_wdata;
    logic [4:0]             w_lo_addr;

`ifdef XC_RF_WB_ROUND_ROBIN_EN
    logic [c_IDX_W-1:0]     r_ptr;

    // Search begins just after the last granted requester.
    always_comb begin : p_select_rr
        int v_idx;
        v_idx       = 0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            v_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = c_IDX_W'(v_idx);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= w_grant_idx;
        end
    end
`else
    always_comb begin : p_select_fixed
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[k]) begin
                w_found     = 1'b1;
                w_grant_idx = c_IDX_W'(k);
            end
        end
    end
`endif

    assign w_fire      = w_found && (r_state == S_IDLE) && i_resetn;
    assign w_ready     = w_fire ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;

    assign w_sel_addr  = bus.req_addr[int'(w_grant_idx)*5 +: 5];
    assign w_sel_wide  = bus.req_wide[w_grant_idx];
    assign w_sel_wdata = bus.req_wdata[int'(w_grant_idx)*2*XLEN +: 2*XLEN];
    assign w_lo_addr   = w_sel_wide ? {w_sel_addr[4:1], 1'b0} : w_sel_addr;

    always_comb begin : p_fsm_next
        w_state_nxt    = r_state;
        w_rd_wen_nxt   = 1'b0;
        w_rd_addr_nxt  = r_rd_addr;
        w_rd_wdata_nxt = r_rd_wdata;
        w_hi_addr_nxt  = r_hi_addr;
        w_hi_wdata_nxt = r_hi_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_rd_addr_nxt  = w_lo_addr;
                    w_rd_wdata_nxt = w_sel_wdata[XLEN-1:0];
                    w_rd_wen_nxt   = (w_lo_addr != 5'd0);
                    if (w_sel_wide) begin
                        w_hi_addr_nxt  = {w_sel_addr[4:1], 1'b1};
                        w_hi_wdata_nxt = w_sel_wdata[2*XLEN-1:XLEN];
                        w_state_nxt    = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                // Odd register of a pair is never x0, so the write is unconditional.
                w_rd_wen_nxt   = 1'b1;
                w_rd_addr_nxt  = r_hi_addr;
                w_rd_wdata_nxt = r_hi_wdata;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state    <= S_IDLE;
            r_rd_wen   <= 1'b0;
            r_rd_addr  <= 5'd0;
            r_rd_wdata <= '0;
            r_hi_addr  <= 5'd0;
            r_hi_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_wen   <= w_rd_wen_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_rd_wdata <= w_rd_wdata_nxt;
            r_hi_addr  <= w_hi_addr_nxt;
            r_hi_wdata <= w_hi_wdata_nxt;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rd_wen    = r_rd_wen;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.rd_wdata  = r_rd_wdata;
    assign bus.busy      = (r_state == S_HIGH);

endmodule
`default_nettype wire

// File: doc/xc_rf_wb_arbiter.md
Name: xc_rf_wb_arbiter

Overview:
Write-back controller for the 3-read-1-write GPR file.
- Shares the single rd write port between NREQ write-back requesters (e.g. ALU, load/store, multi-cycle crypto unit) using a valid/ready handshake.
- Sequences "wide" 64-bit results into an even/odd register pair over two consecutive write cycles.
- Drives the register file's rd_wen/rd_addr/rd_wdata from registers, giving one cycle of latency.

Parameters:
NREQ, 3, number of write-back requesters (2..8).
XLEN, 32, register width; wide results are 2*XLEN.

Ports:
clock  in  1  system clock; all state updates on posedge.
resetn  in  1  synchronous active-low reset.
req_valid  in  NREQ  requester i has a result pending.
req_ready  out  NREQ  grant; handshake fires when req_valid[i] & req_ready[i].
req_addr  in  5*NREQ  destination register, slice i = [5i+4:5i].
req_wide  in  NREQ  result is 2*XLEN, written to an even/odd pair.
req_wdata  in  2*XLEN*NREQ  result data; the upper half is ignored unless wide.
rd_wen  out  1  register file write enable (registered).
rd_addr  out  5  register file write address (registered).
rd_wdata  out  XLEN  register file write data (registered).
busy  out  1  high while the second half of a wide write is pending.

Behaviour:
- FSM states: IDLE and HIGH. Reset state is IDLE.
- Reset (resetn=0 at posedge):
  - state=IDLE, rd_wen=0, rd_addr=0, rd_wdata=0, priority pointer=0.
  - req_ready is forced to all-zero combinationally while resetn=0.
  - A pending wide upper half is discarded when reset arrives mid-operation; no write occurs.
- IDLE:
  - Winner w is selected combinationally among the set req_valid bits.
  - req_ready is one-hot at w, or zero if no request is valid. req_ready may depend combinationally on req_valid.
  - Requesters hold addr, wide and wdata stable from valid assertion until the handshake.
  - On handshake, at the next posedge:
    - rd_addr <= wide ? {addr[4:1],1'b0} : addr.
    - rd_wdata <= wdata[XLEN-1:0].
    - rd_wen <= (that address != 0).
  - If wide: also capture wdata[2XLEN-1:XLEN] and {addr[4:1],1'b1}, then go to HIGH.
  - No handshake: rd_wen <= 0 and rd_addr/rd_wdata hold their values.
- HIGH:
  - req_ready = 0 and busy = 1.
  - At the next posedge: rd_wen <= 1, rd_addr <= captured odd address, rd_wdata <= captured upper half; go to IDLE.
- Latency and throughput:
  - Handshake in cycle N gives the rd write in cycle N+1.
  - A wide result writes its low half in N+1 and its high half in N+2.
  - Narrow throughput: 1 per cycle. Wide throughput: 1 per 2 cycles.
  - Back-to-back narrow grants are allowed every cycle.
- Address rules:
  - Writes to x0 are suppressed: rd_wen stays 0 while rd_addr/rd_wdata still update.
  - For a wide request, addr[0] is ignored.
  - A wide write to x0/x1 suppresses the low half and writes x1.
- Simultaneous requests: exactly one grant per cycle. Losers keep valid asserted and are unaffected.
- A requester deasserting valid without a handshake is legal and has no effect.
- Default selection (fixed priority): lowest index wins. The priority pointer is unused.

Optional Feature:
XC_RF_WB_ROUND_ROBIN_EN:
- Defined: round-robin arbitration.
  - The pointer holds the index of the last granted requester.
  - Search starts at (pointer+1) mod NREQ.
  - The pointer updates only on a handshake; during HIGH it is frozen.
  - Reset sets the pointer to 0, so requester 1 has first priority after reset.
- Undefined: fixed priority, lowest index wins, and no pointer register is built.

Test Plan:
- Reset: hold resetn=0 with all req_valid=1 -> req_ready=0, rd_wen=0, rd_addr=0, rd_wdata=0, busy=0. First grant goes to index 0 after release (fixed priority).
- Single narrow write: req_valid[1]=1, addr=5, wdata=0xDEADBEEF in cycle N -> req_ready[1]=1 in N; rd_wen=1, rd_addr=5, rd_wdata=0xDEADBEEF in N+1; rd_wen=0 in N+2.
- Wide write:
  - Stimulus: req_valid[2], wide=1, addr=7, wdata=0x11112222_33334444.
  - Response: N+1 writes x6=0x33334444; N+2 writes x7=0x11112222 with busy=1 during N+1.
  - A req_valid[0] held throughout is not granted until N+2 and writes in N+3.
- Contention: all three valid every cycle, narrow, addrs 1/2/3.
  - Fixed priority: only requester 0 is granted, every cycle.
  - With XC_RF_WB_ROUND_ROBIN_EN: grant order 1,2,0,1,2,0 from reset.
- x0 suppression: narrow addr=0 -> handshake completes, rd_wen stays 0. Wide addr=0 -> low half suppressed, x1 written in N+2.
- Reset mid-operation: assert resetn=0 at the posedge ending N+1 of a wide write -> no high-half write, state IDLE, busy=0, rd_wen=0.
